// File: rtl/count_seg_display.sv
// Wrap monitor and 2-digit multiplexed 7-segment driver for the 3-bit up/down counter.
// Define COUNT_DISP_TALLY_EN to enable the wrap tally, digit1 and digit multiplexing.
module count_seg_display #(
   parameter int unsigned REFRESH_DIV    = 1024,
   parameter int unsigned WRAP_FLASH_CYC = 4096,
   parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [2:0] count,
   input  logic       up_down,
   output logic [6:0] seg,
   output logic [1:0] an,
   output logic       dp,
   output logic       wrap_led,
   output logic [3:0] wrap_tally
);

   localparam int unsigned FLASH_W = $clog2(WRAP_FLASH_CYC + 1);
   localparam logic [FLASH_W-1:0] FLASH_LOAD = FLASH_W'(WRAP_FLASH_CYC);
   localparam logic POL = SEG_ACTIVE_LOW;

   typedef enum logic {DIGIT0, DIGIT1} digit_t;

   logic [2:0]         count_q;
   logic [2:0]         prev_q;
   logic               dir_q;
   logic               prime_stage;
   logic               primed;
   logic               up_wrap;
   logic               down_wrap;
   logic [FLASH_W-1:0] flash_cnt;
   logic [FLASH_W-1:0] flash_next;
   digit_t             sel;

   function automatic logic [6:0] decode(input logic [3:0] v);
      logic [6:0] s;
      case (v)
         4'h0: s = 7'h3F;
         4'h1: s = 7'h06;
         4'h2: s = 7'h5B;
         4'h3: s = 7'h4F;
         4'h4: s = 7'h66;
         4'h5: s = 7'h6D;
         4'h6: s = 7'h7D;
         4'h7: s = 7'h07;
         4'h8: s = 7'h7F;
         4'h9: s = 7'h6F;
         4'hA: s = 7'h77;
         4'hB: s = 7'h7C;
         4'hC: s = 7'h39;
         4'hD: s = 7'h5E;
         4'hE: s = 7'h79;
         default: s = 7'h71;
      endcase
      return s;
   endfunction

   // primed needs two clocks so that both count_q and prev_q hold post-reset samples
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_q     <= '0;
         prev_q      <= '0;
         dir_q       <= 1'b0;
         prime_stage <= 1'b0;
         primed      <= 1'b0;
      end else begin
         count_q     <= count;
         prev_q      <= count_q;
         dir_q       <= up_down;
         prime_stage <= 1'b1;
         primed      <= prime_stage;
      end
   end

   assign up_wrap   = primed && (prev_q == 3'd7) && (count_q == 3'd0);
   assign down_wrap = primed && (prev_q == 3'd0) && (count_q == 3'd7);

   always_comb begin
      flash_next = flash_cnt;
      if (up_wrap || down_wrap)
         flash_next = FLASH_LOAD;
      else if (flash_cnt != '0)
         flash_next = flash_cnt - 1'b1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         flash_cnt <= '0;
         wrap_led  <= 1'b0;
      end else begin
         flash_cnt <= flash_next;
         wrap_led  <= (flash_next != '0);
      end
   end

`ifdef COUNT_DISP_TALLY_EN
   localparam int unsigned REF_W = $clog2(REFRESH_DIV);
   localparam logic [REF_W-1:0] REF_LAST = REF_W'(REFRESH_DIV - 1);

   logic [REF_W-1:0] ref_cnt;
   logic [3:0]       tally_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tally_q <= '0;
      end else if (up_wrap && (tally_q != 4'hF)) begin
         tally_q <= tally_q + 1'b1;
      end else if (down_wrap && (tally_q != 4'h0)) begin
         tally_q <= tally_q - 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ref_cnt <= '0;
         sel     <= DIGIT0;
      end else if (ref_cnt == REF_LAST) begin
         ref_cnt <= '0;
         sel     <= (sel == DIGIT0) ? DIGIT1 : DIGIT0;
      end else begin
         ref_cnt <= ref_cnt + 1'b1;
      end
   end

   assign wrap_tally = tally_q;
`else
   assign wrap_tally = '0;
   assign sel        = DIGIT0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         seg <= {7{POL}};
         an  <= {2{POL}};
         dp  <= POL;
      end else begin
         case (sel)
            DIGIT0: begin
               an  <= 2'b01 ^ {2{POL}};
               seg <= decode({1'b0, count_q}) ^ {7{POL}};
               dp  <= dir_q ^ POL;
            end
            default: begin
               an  <= 2'b10 ^ {2{POL}};
               seg <= decode(wrap_tally) ^ {7{POL}};
               dp  <= POL;
            end
         endcase
      end
   end

endmodule
